// File: rtl/qspi_mem_bridge.sv
// qspi_mem_bridge: byte-wide CPU port onto a word-wide QSPI controller with an optional
// one-word cache, enabled by defining QSPI_BRIDGE_CACHE_EN (default build: cache disabled).
module qspi_mem_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [23:0] addr,
   input  logic [7:0]  wdata,
   input  logic        flush,
   output logic [7:0]  rdata,
   output logic        ready,
   output logic        q_start,
   output logic        q_write,
   input  logic        q_busy,
   output logic [23:0] q_address,
   output logic [31:0] q_data_in,
   input  logic [31:0] q_data_out
);
   typedef enum logic [3:0] {
      IDLE, HIT, RD_START, RD_WAIT_ACK, RD_WAIT_DONE,
      MERGE, WR_START, WR_WAIT_ACK, WR_WAIT_DONE, DONE
   } state_t;
   state_t      state_q, state_d;
   logic        valid_q, valid_d, pend_q, pend_d, we_q, we_d;
   logic [21:0] tag_q, tag_d;
   logic [31:0] data_q, data_d;
   logic [23:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        ready_q, ready_d, q_start_q, q_start_d, q_write_q, q_write_d;
   logic [7:0]  rdata_q, rdata_d;
   logic [23:0] q_address_q, q_address_d;
   logic [31:0] q_data_in_q, q_data_in_d;
   logic        hit;
   logic [31:0] merged;
   // Offset 0 is the most significant byte, matching MSB-first shifting on the bus.
   function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] o);
      return o == 2'd0 ? w[31:24] : o == 2'd1 ? w[23:16] : o == 2'd2 ? w[15:8] : w[7:0];
   endfunction
   function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] o, input logic [7:0] b);
      return o == 2'd0 ? {b, w[23:0]} :
             o == 2'd1 ? {w[31:24], b, w[15:0]} :
             o == 2'd2 ? {w[31:16], b, w[7:0]} : {w[31:8], b};
   endfunction
   // A flush arriving together with a request wins, so that request is a miss.
   assign hit    = valid_q && !flush && tag_q == addr[23:2];
   assign merged = put_byte(data_q, addr_q[1:0], wdata_q);
   // Next-state and registered-output computation for the access sequencer.
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      pend_d      = state_q == IDLE ? 1'b0 : pend_q | flush;
      we_d        = we_q;
      tag_d       = tag_q;
      data_d      = data_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      ready_d     = 1'b0;
      rdata_d     = 8'h00;
      q_start_d   = 1'b0;
      q_write_d   = q_write_q;
      q_address_d = q_address_q;
      q_data_in_d = q_data_in_q;
      case (state_q)
         IDLE: begin
            if (flush) valid_d = 1'b0;
            if (req && (hit || !q_busy)) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               if (hit && we) state_d = MERGE;
               else if (hit) begin
                  state_d = HIT;
                  ready_d = 1'b1;
                  rdata_d = sel_byte(data_q, addr[1:0]);
               end else begin
                  state_d     = RD_START;
                  q_start_d   = 1'b1;
                  q_write_d   = 1'b0;
                  q_address_d = {addr[23:2], 2'b00};
               end
            end
         end
         HIT, DONE: begin
            state_d = IDLE;
            pend_d  = 1'b0;
            if (pend_q || flush) valid_d = 1'b0;
         end
         RD_START:    state_d = RD_WAIT_ACK;
         RD_WAIT_ACK: state_d = RD_WAIT_DONE;
         RD_WAIT_DONE: begin
            if (!q_busy) begin
               data_d = q_data_out;
               tag_d  = addr_q[23:2];
`ifdef QSPI_BRIDGE_CACHE_EN
               valid_d = 1'b1;
`else
               valid_d = 1'b0;
`endif
               if (we_q) state_d = MERGE;
               else begin
                  state_d = DONE;
                  ready_d = 1'b1;
                  rdata_d = sel_byte(q_data_out, addr_q[1:0]);
               end
            end
         end
         MERGE: begin
            data_d = merged;
            if (!q_busy) begin
               state_d     = WR_START;
               q_start_d   = 1'b1;
               q_write_d   = 1'b1;
               q_data_in_d = merged;
               q_address_d = {addr_q[23:2], 2'b00};
            end
         end
         WR_START:    state_d = WR_WAIT_ACK;
         WR_WAIT_ACK: state_d = WR_WAIT_DONE;
         WR_WAIT_DONE: begin
            if (!q_busy) begin
               state_d = DONE;
               ready_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // All state and outputs registered; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         valid_q     <= 1'b0;
         pend_q      <= 1'b0;
         we_q        <= 1'b0;
         tag_q       <= '0;
         data_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         q_start_q   <= 1'b0;
         q_write_q   <= 1'b0;
         q_address_q <= '0;
         q_data_in_q <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         pend_q      <= pend_d;
         we_q        <= we_d;
         tag_q       <= tag_d;
         data_q      <= data_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         q_start_q   <= q_start_d;
         q_write_q   <= q_write_d;
         q_address_q <= q_address_d;
         q_data_in_q <= q_data_in_d;
      end
   end
   assign ready     = ready_q;
   assign rdata     = rdata_q;
   assign q_start   = q_start_q;
   assign q_write   = q_write_q;
   assign q_address = q_address_q;
   assign q_data_in = q_data_in_q;
endmodule
